imem_server: RTL



---
 rtl/imem_server_if.sv | 29 ++
 rtl/imem_server.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/imem_server_if.sv
// Fetch and program-load signal bundle between the core/host side and imem_server.
interface imem_server_if #(
  parameter int NMEM = 64
) ();
  localparam int AW = $clog2(NMEM);

  logic [31:0] pc;
  logic [31:0] inst;
  logic        pcEn;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        start;
  logic        halted;
  logic        err_oob;
  logic [AW:0] load_count;
  logic [31:0] fetch_count;

  modport master (
    output pc, ld_valid, ld_data, ld_last, start,
    input  inst, pcEn, ld_ready, halted, err_oob, load_count, fetch_count
  );

  modport slave (
    input  pc, ld_valid, ld_data, ld_last, start,
    output inst, pcEn, ld_ready, halted, err_oob, load_count, fetch_count
  );
endinterface

// File: rtl/imem_server.sv
// Instruction-memory responder: host loads a program image, then the core fetches
// from it with zero latency until a halt word or a bad fetch stops the run.
module imem_server #(
  parameter int          NMEM      = 64,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  imem_server_if.slave bus
);
  localparam int AW = $clog2(NMEM);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_READY = 2'd1,
    S_RUN   = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem_q [NMEM];
  logic [AW:0]   load_count_q, load_count_d;
  logic [31:0]   fetch_count_q, fetch_count_d;
  logic          err_oob_q, err_oob_d;

  logic [AW-1:0] widx_s;
  logic [31:0]   word_s;
  logic [31:0]   pc_limit_s;
  logic          aligned_s, in_range_s, is_halt_s, fetch_ok_s;
  logic          ld_fire_s, ld_end_s;
  logic [31:0]   inst_s;
  logic          pc_en_s, ld_ready_s, halted_s;

  assign widx_s     = bus.pc[AW+1:2];
  assign word_s     = mem_q[widx_s];
  assign pc_limit_s = {{(32-AW-3){1'b0}}, load_count_q, 2'b00};
  assign aligned_s  = (bus.pc[1:0] == 2'b00);
  assign in_range_s = (bus.pc < pc_limit_s);
  assign is_halt_s  = (word_s == HALT_WORD);
  assign fetch_ok_s = (state_q == S_RUN) && aligned_s && in_range_s && !is_halt_s;
  assign ld_fire_s  = (state_q == S_LOAD) && bus.ld_valid;
  assign ld_end_s   = bus.ld_last || (load_count_q == (AW+1)'(NMEM - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (ld_fire_s && ld_end_s) state_d = S_READY; else state_d = S_LOAD;
      S_READY: if (bus.start)             state_d = S_RUN;   else state_d = S_READY;
      S_RUN:   if (!fetch_ok_s)           state_d = S_HALT;  else state_d = S_RUN;
      S_HALT:  if (bus.start)             state_d = S_LOAD;  else state_d = S_HALT;
      default: state_d = S_LOAD;
    endcase
  end

  // Output decode; pcEn depends on the state register only.
  always_comb begin
    inst_s     = NOP_WORD;
    pc_en_s    = 1'b0;
    ld_ready_s = 1'b0;
    halted_s   = 1'b0;
    case (state_q)
      S_LOAD:  ld_ready_s = 1'b1;
      S_READY: ld_ready_s = 1'b0;
      S_RUN: begin
        pc_en_s = 1'b1;
        inst_s  = fetch_ok_s ? word_s : NOP_WORD;
      end
      S_HALT:  halted_s = 1'b1;
      default: inst_s = NOP_WORD;
    endcase
  end

  // Counter and error-flag next values.
  always_comb begin
    load_count_d  = load_count_q;
    fetch_count_d = fetch_count_q;
    err_oob_d     = err_oob_q;
    case (state_q)
      S_LOAD: begin
        if (ld_fire_s) load_count_d = load_count_q + (AW+1)'(1);
        else           load_count_d = load_count_q;
      end
      S_READY: begin
        if (bus.start) begin
          fetch_count_d = 32'd0;
          err_oob_d     = 1'b0;
        end else begin
          fetch_count_d = fetch_count_q;
        end
      end
      S_RUN: begin
        if (fetch_ok_s) begin
          fetch_count_d = (fetch_count_q == 32'hFFFF_FFFF) ? fetch_count_q
                                                           : fetch_count_q + 32'd1;
        end else if (!aligned_s || !in_range_s) begin
          err_oob_d = 1'b1;
        end else begin
          err_oob_d = err_oob_q;
        end
      end
      S_HALT: begin
        if (bus.start) load_count_d = '0;
        else           load_count_d = load_count_q;
      end
      default: load_count_d = load_count_q;
    endcase
  end

  // Counter and error-flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_count_q  <= '0;
      fetch_count_q <= 32'd0;
      err_oob_q     <= 1'b0;
    end else begin
      load_count_q  <= load_count_d;
      fetch_count_q <= fetch_count_d;
      err_oob_q     <= err_oob_d;
    end
  end

  // Program array; intentionally not reset, load_count alone bounds valid fetches.
  always_ff @(posedge clk) begin
    if (ld_fire_s) begin
      mem_q[load_count_q[AW-1:0]] <= bus.ld_data;
    end
  end

  assign bus.inst        = inst_s;
  assign bus.pcEn        = pc_en_s;
  assign bus.ld_ready    = ld_ready_s;
  assign bus.halted      = halted_s;
  assign bus.err_oob     = err_oob_q;
  assign bus.load_count  = load_count_q;
  assign bus.fetch_count = fetch_count_q;
endmodule
